// File: rtl/axi4_psram_wb_bridge.sv
// AXI4 slave to Wishbone master bridge for a PSRAM controller.
// Handles one AXI transaction at a time. Each beat becomes one WB word access,
// or a series of single-byte accesses when the write strobe pattern cannot be
// expressed as one aligned byte, halfword or word. Reads and writes alternate
// when both address channels are valid at once.
module axi4_psram_wb_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // AXI write address
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic              awvalid,
  output logic              awready,
  // AXI write data
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // AXI write response
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // AXI read address
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic              arvalid,
  output logic              arready,
  // AXI read data
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // Wishbone master
  output logic [ADDR_W-1:0] adr_o,
  output logic [31:0]       dat_o,
  input  logic [31:0]       dat_i,
  output logic [3:0]        sel_o,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  input  logic              ack_i
);

  localparam logic [1:0]        OKAY   = 2'b00;
  localparam logic [1:0]        SLVERR = 2'b10;
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(4);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_WB = 3'd1,
    RD_R  = 3'd2,
    WR_W  = 3'd3,
    WR_WB = 3'd4,
    WR_B  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        len;
  logic [7:0]        beat;
  logic              serr;
  logic              last_wr;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [3:0]        pend;
  logic [3:0]        pend_left;
  logic              stb;
  logic              ack;
  logic              last_beat;
  logic              ar_go;
  logic              aw_go;
  logic              w_go;
  logic              r_go;
  logic              b_go;
  logic              w_skip;
  logic              wb_done;

  // Bursts only make sense for full-word beats; anything wider than a word is unsupported.
  function automatic logic size_bad(input logic [2:0] size, input logic [7:0] blen);
    return (size > 3'd2) || ((size < 3'd2) && (blen != 8'd0));
  endfunction

  // Strobe patterns the PSRAM controller accepts as a single access.
  function automatic logic strb_whole(input logic [3:0] s);
    logic ok;
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] low_lane(input logic [3:0] m);
    return m & (~m + 4'd1);
  endfunction

  // A stale ack while no strobe is out must never be taken as a completion.
  assign ack       = stb & ack_i;
  assign last_beat = (beat == len);
  assign word_addr = {addr[ADDR_W-1:2], 2'b00};

  // Alternating arbiter: last_wr set means the write side was granted last.
  assign ar_go   = (state == IDLE) && arvalid && (!awvalid || last_wr);
  assign aw_go   = (state == IDLE) && awvalid && !ar_go;
  assign arready = ar_go;
  assign awready = aw_go;

  assign wready = (state == WR_W);
  assign rvalid = (state == RD_R);
  assign bvalid = (state == WR_B);
  assign w_go   = wready & wvalid;
  assign r_go   = rvalid & rready;
  assign b_go   = bvalid & bready;
  assign w_skip = serr || (wstrb == 4'b0000);

  assign pend_left = pend & ~sel_o;
  assign wb_done   = ack && (pend_left == 4'b0000);

  assign cyc_o = stb;
  assign stb_o = stb;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ar_go)      state_nxt = RD_WB;
        else if (aw_go) state_nxt = WR_W;
      end
      RD_WB: if (serr || ack) state_nxt = RD_R;
      RD_R:  if (r_go) state_nxt = last_beat ? IDLE : RD_WB;
      WR_W: begin
        if (w_go) begin
          if (w_skip) state_nxt = last_beat ? WR_B : WR_W;
          else        state_nxt = WR_WB;
        end
      end
      WR_WB: if (wb_done) state_nxt = last_beat ? WR_B : WR_W;
      WR_B:  if (b_go) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction context, WB bus drive and AXI response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      len     <= '0;
      beat    <= '0;
      serr    <= 1'b0;
      last_wr <= 1'b1;
      wdata_q <= '0;
      wstrb_q <= '0;
      pend    <= '0;
      stb     <= 1'b0;
      adr_o   <= '0;
      dat_o   <= '0;
      sel_o   <= '0;
      we_o    <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
      rlast   <= 1'b0;
      bresp   <= OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (ar_go) begin
            addr    <= araddr;
            len     <= arlen;
            beat    <= 8'd0;
            serr    <= size_bad(arsize, arlen);
            last_wr <= 1'b0;
          end else if (aw_go) begin
            addr    <= awaddr;
            len     <= awlen;
            beat    <= 8'd0;
            serr    <= size_bad(awsize, awlen);
            last_wr <= 1'b1;
            bresp   <= size_bad(awsize, awlen) ? SLVERR : OKAY;
          end
        end
        RD_WB: begin
          if (serr) begin
            rdata <= '0;
            rresp <= SLVERR;
            rlast <= last_beat;
          end else if (!stb) begin
            stb   <= 1'b1;
            adr_o <= word_addr;
            sel_o <= 4'b1111;
            we_o  <= 1'b0;
          end else if (ack) begin
            stb   <= 1'b0;
            rdata <= dat_i;
            rresp <= OKAY;
            rlast <= last_beat;
          end
        end
        RD_R: begin
          if (r_go) begin
            rlast <= 1'b0;
            if (!last_beat) begin
              beat <= beat + 8'd1;
              addr <= addr + STEP;
            end
          end
        end
        WR_W: begin
          if (w_go) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            pend    <= wstrb;
            if (wlast != last_beat) bresp <= SLVERR;
            if (w_skip && !last_beat) begin
              beat <= beat + 8'd1;
              addr <= addr + STEP;
            end
          end
        end
        WR_WB: begin
          if (!stb) begin
            stb   <= 1'b1;
            we_o  <= 1'b1;
            adr_o <= word_addr;
            dat_o <= wdata_q;
            sel_o <= strb_whole(wstrb_q) ? wstrb_q : low_lane(pend);
          end else if (ack) begin
            stb  <= 1'b0;
            we_o <= 1'b0;
            pend <= pend_left;
            if ((pend_left == 4'b0000) && !last_beat) begin
              beat <= beat + 8'd1;
              addr <= addr + STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axi4_psram_wb_bridge.md
AXI4_PSRAM_WB_BRIDGE -- requirements
Module: axi4_psram_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the width of AXI and WB addresses.
REQ-002 SHALL have a single clock and an asynchronous, active-low reset: `clk  in  1` (all state on rising edge) and `rst_n  in  1` (asynchronous assert, active low).
REQ-003 SHALL have the AXI AW channel: `awaddr  in  ADDR_W`, `awlen  in  8`, `awsize  in  3`, `awvalid  in  1`, `awready  out  1`.
REQ-004 SHALL have the AXI W channel: `wdata  in  32`, `wstrb  in  4`, `wlast  in  1`, `wvalid  in  1`, `wready  out  1`.
REQ-005 SHALL have the AXI B channel: `bresp  out  2`, `bvalid  out  1`, `bready  in  1`.
REQ-006 SHALL have the AXI AR channel: `araddr  in  ADDR_W`, `arlen  in  8`, `arsize  in  3`, `arvalid  in  1`, `arready  out  1`.
REQ-007 SHALL have the AXI R channel: `rdata  out  32`, `rresp  out  2`, `rlast  out  1`, `rvalid  out  1`, `rready  in  1`.
REQ-008 SHALL have the WB master port to the PSRAM controller: `adr_o  out  ADDR_W`, `dat_o  out  32`, `dat_i  in  32`, `sel_o  out  4`, `cyc_o  out  1`, `stb_o  out  1`, `we_o  out  1`, `ack_i  in  1`.

Function
REQ-009 SHALL be an FSM with states IDLE, RD_WB, RD_R, WR_W, WR_WB, WR_B, handling one AXI transaction at a time.
REQ-010 SHALL drive arready/awready high only in IDLE; awready and arready are never high together.
REQ-011 SHALL arbitrate in IDLE when both awvalid and arvalid are high by alternating: grant the class not granted last; after reset, read wins.
REQ-012 SHALL latch address, len and size on the AR/AW handshake, and enter RD_WB or WR_W the next cycle.
REQ-013 SHALL assert cyc_o=stb_o=1 the cycle after entering RD_WB or WR_WB, holding adr_o, dat_o, sel_o and we_o stable until ack_i.
REQ-014 SHALL clear cyc_o/stb_o on the clock edge that samples ack_i=1, keeping stb_o low for at least one cycle before any next WB access.
REQ-015 SHALL issue reads with adr_o = {addr[ADDR_W-1:2],2'b00}, sel_o=4'b1111, we_o=0.
REQ-016 SHALL on read ack capture dat_i into rdata, set rresp=OKAY and rvalid=1, and enter RD_R.
REQ-017 SHALL in RD_R hold rvalid/rdata/rlast until rready; after the handshake go to RD_WB for the next beat, or to IDLE after the last beat.
REQ-018 SHALL assert rlast only on beat number len (0-based).
REQ-019 SHALL advance the address by +4 per beat, full ADDR_W width with modular wrap-around.
REQ-020 SHALL assert wready only in WR_W; on the W handshake it latches wdata/wstrb and moves to WR_WB.
REQ-021 SHALL issue the write as one WB access when wstrb ∈ {0001,0010,0100,1000,0011,1100,1111}, with sel_o=wstrb and dat_o=wdata.
REQ-022 SHALL for any other nonzero wstrb split the beat into single-byte WB writes, lowest lane first, one per set bit.
REQ-023 SHALL for wstrb=0000 make no WB access and return directly to WR_W, or to WR_B on the last beat.
REQ-024 SHALL count beats by awlen and ignore wlast for sequencing; a wlast mismatch on any beat sets bresp=SLVERR.
REQ-025 SHALL in WR_B hold bvalid=1 until bready, then return to IDLE.
REQ-026 SHALL treat size>2, or size<2 with len>0, as an error: no WB access, all beats still exchanged, rdata=0, rresp/bresp=SLVERR.
REQ-027 SHALL ignore ack_i when stb_o=0.

Reset
REQ-028 SHALL on rst_n=0 immediately force state IDLE, with cyc_o, stb_o, we_o, rvalid, rlast and bvalid all 0.
REQ-029 SHALL reset adr_o, dat_o, sel_o and rdata to 0, bresp and rresp to OKAY, and the arbiter to read-priority.
REQ-030 SHALL on reset mid-transaction abandon it with no response; the first AR/AW after release starts fresh.

Verification
REQ-031 Single read araddr=0x80000104, len=0, ack_i after 5 cycles with dat_i=0xDEADBEEF -> adr_o=0x80000104, sel_o=1111, rdata=0xDEADBEEF, rlast=1, rresp=0.
REQ-032 INCR read len=3 with rready stalled 3 cycles on beat 1 -> 4 WB reads at +0,+4,+8,+C, each starting only after the prior R handshake, rlast on beat 3 only.
REQ-033 Write wstrb=0101 with wdata=0x11223344 -> two WB writes: sel 0001 then 0100, stb_o low ≥1 cycle between them, then a single bvalid with bresp=OKAY.
REQ-034 awvalid and arvalid asserted together from reset, repeatedly -> grant order read, write, read, write.
REQ-035 Write len=1 with wlast on beat 0 -> two WB writes, bresp=SLVERR; arsize=3 read -> no stb_o, rresp=SLVERR, rdata=0.
REQ-036 rst_n pulsed low while stb_o=1 in RD_WB -> stb_o, cyc_o and rvalid drop without a clock edge; no R beat is produced after release.
